score_scan_display: RTL and testbench

// - Parametrised successor to the fixed 8-digit coin display path: NUM_CH independent BCD

---
 rtl/score_disp_pkg.sv | 38 +++
 rtl/score_scan_display_if.sv | 24 ++
 rtl/bcd_counter.sv | 78 +++++++
 rtl/score_scan_display.sv | 89 ++++++++
 tb/tb_score_scan_display.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_disp_pkg.sv
// Shared constants and helpers for the score counter / seven-segment display path.
package score_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_NINE  = 4'd9;

    // Minimum bit width able to hold value-1, never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // BCD digit to active-low {g..a} pattern; anything that is not 0-9 goes dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/score_scan_display_if.sv
// Event pulses from game logic in, BCD counts and display pins out.
interface score_scan_display_if #(
    parameter int NUM_CH = 2,
    parameter int DIGITS = 4
);
    logic [NUM_CH-1:0]          Inc_In;
    logic [NUM_CH-1:0]          Dec_In;
    logic [NUM_CH-1:0]          Clear_In;
    logic [NUM_CH*DIGITS*4-1:0] Count_Out;
    logic [NUM_CH-1:0]          Sat_Out;
    logic [NUM_CH-1:0]          Uflow_Out;
    logic [6:0]                 Seg_Out;
    logic [NUM_CH*DIGITS-1:0]   An_Out;

    modport master (
        output Inc_In, Dec_In, Clear_In,
        input  Count_Out, Sat_Out, Uflow_Out, Seg_Out, An_Out
    );

    modport slave (
        input  Inc_In, Dec_In, Clear_In,
        output Count_Out, Sat_Out, Uflow_Out, Seg_Out, An_Out
    );
endinterface

// File: rtl/bcd_counter.sv
// One multi-digit BCD counter: clear beats everything, simultaneous inc/dec cancel,
// increment saturates at all nines, decrement at zero holds and flags underflow.
module bcd_counter
    import score_disp_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    input  logic                clear,
    output logic [DIGITS*4-1:0] value,
    output logic                sat,
    output logic                uflow
);

    logic [DIGITS*4-1:0] inc_val;
    logic [DIGITS*4-1:0] dec_val;
    logic                all_nine;
    logic                all_zero;
    logic                carry;
    logic                borrow;
    logic [3:0]          digit;

    // Ripple the carry and borrow through the digits and detect the two end stops.
    always_comb begin
        inc_val  = value;
        dec_val  = value;
        all_nine = 1'b1;
        all_zero = 1'b1;
        carry    = 1'b1;
        borrow   = 1'b1;
        digit    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            digit = value[k*4 +: 4];
            if (digit != BCD_NINE) all_nine = 1'b0;
            if (digit != 4'd0)     all_zero = 1'b0;
            if (carry) begin
                if (digit == BCD_NINE) begin
                    inc_val[k*4 +: 4] = 4'd0;
                end else begin
                    inc_val[k*4 +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_val[k*4 +: 4] = BCD_NINE;
                end else begin
                    dec_val[k*4 +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    assign sat = all_nine;

    // Commit the selected update; the underflow flag lives for exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
            uflow <= 1'b0;
        end else begin
            uflow <= 1'b0;
            if (clear) begin
                value <= '0;
            end else if (inc && !dec) begin
                if (!all_nine) value <= inc_val;
            end else if (dec && !inc) begin
                if (all_zero) uflow <= 1'b1;
                else          value <= dec_val;
            end
        end
    end

endmodule

// File: rtl/score_scan_display.sv
// NUM_CH BCD score counters feeding a time-multiplexed seven-segment scanner
// with optional per-channel leading-zero blanking.
module score_scan_display
    import score_disp_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 25_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                 Master_Clock_In,
    input  logic                 Reset_N_In,
    score_scan_display_if.slave  bus
);

    localparam int TOTAL = NUM_CH * DIGITS;
    localparam int DIV   = CLK_HZ / (SCAN_HZ * TOTAL);
    localparam int PRE_W = clog2(DIV);
    localparam int IDX_W = clog2(TOTAL);

    logic [NUM_CH*DIGITS*4-1:0] count;
    logic [NUM_CH-1:0]          sat;
    logic [NUM_CH-1:0]          uflow;
    logic [PRE_W-1:0]           prescale;
    logic [IDX_W-1:0]           index;
    logic [6:0]                 seg_q;
    logic [TOTAL-1:0]           an_q;
    logic [6:0]                 seg_next;
    logic [TOTAL-1:0]           an_next;
    logic                       upper_zero;
    int                         pos;
    int                         ch;
    int                         dig;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        bcd_counter #(.DIGITS(DIGITS)) u_counter (
            .clk   (Master_Clock_In),
            .rst_n (Reset_N_In),
            .inc   (bus.Inc_In[c]),
            .dec   (bus.Dec_In[c]),
            .clear (bus.Clear_In[c]),
            .value (count[c*DIGITS*4 +: DIGITS*4]),
            .sat   (sat[c]),
            .uflow (uflow[c])
        );
    end

    // Pick the digit for the current scan position and decide whether it is a leading zero.
    always_comb begin
        pos        = int'(index);
        ch         = pos / DIGITS;
        dig        = pos % DIGITS;
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= dig && count[(ch*DIGITS + k)*4 +: 4] != 4'd0) upper_zero = 1'b0;
        end
        if (BLANK_LZ != 0 && dig > 0 && upper_zero) seg_next = SEG_BLANK;
        else                                        seg_next = seg_decode(count[pos*4 +: 4]);
        an_next = ~(TOTAL'(1) << index);
    end

    // Prescaler paces the scan; segment and anode pins are registered from the current index.
    always_ff @(posedge Master_Clock_In) begin
        if (!Reset_N_In) begin
            prescale <= '0;
            index    <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= '1;
        end else begin
            if (prescale == PRE_W'(DIV - 1)) begin
                prescale <= '0;
                if (index == IDX_W'(TOTAL - 1)) index <= '0;
                else                            index <= index + 1'b1;
            end else begin
                prescale <= prescale + 1'b1;
            end
            seg_q <= seg_next;
            an_q  <= an_next;
        end
    end

    assign bus.Count_Out = count;
    assign bus.Sat_Out   = sat;
    assign bus.Uflow_Out = uflow;
    assign bus.Seg_Out   = seg_q;
    assign bus.An_Out    = an_q;

endmodule

// File: tb/tb_score_scan_display.sv
// Randomised self-checking bench: decimal reference model of the counters and scan timing.
module tb_score_scan_display;

    localparam int NUM_CH  = 2;
    localparam int DIGITS  = 4;
    localparam int CLK_HZ  = 8000;
    localparam int SCAN_HZ = 500;
    localparam int TOTAL   = NUM_CH * DIGITS;
    localparam int DIV     = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] inc;
    logic [1:0] dec;
    logic [1:0] clr;

    int         checks;
    int         failures;

    int         mval [NUM_CH];
    logic [1:0] exp_uflow;
    int         t;
    logic [6:0] exp_seg;
    logic [6:0] exp_seg_nb;
    logic [7:0] exp_an;
    int         exp_pos;

    score_scan_display_if #(.NUM_CH(NUM_CH), .DIGITS(DIGITS)) bus0 ();
    score_scan_display_if #(.NUM_CH(NUM_CH), .DIGITS(DIGITS)) bus1 ();

    assign bus0.Inc_In   = inc;
    assign bus0.Dec_In   = dec;
    assign bus0.Clear_In = clr;
    assign bus1.Inc_In   = inc;
    assign bus1.Dec_In   = dec;
    assign bus1.Clear_In = clr;

    score_scan_display #(
        .NUM_CH(NUM_CH), .DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_LZ(1)
    ) dut (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_n),
        .bus             (bus0)
    );

    score_scan_display #(
        .NUM_CH(NUM_CH), .DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_LZ(0)
    ) dut_nb (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_n),
        .bus             (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int pow10(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    // Active-low {g..a}: segments lit for each decimal digit.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [31:0] exp_count();
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < DIGITS; k++)
                r[(c*DIGITS + k)*4 +: 4] = 4'((mval[c] / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [1:0] exp_sat();
        logic [1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = (mval[c] == 9999);
        return r;
    endfunction

    // Advance one clock edge and update the reference model with the inputs seen at that edge.
    task automatic tick();
        int ch;
        int k;
        int d;
        @(posedge clk);
        if (!rst_n) begin
            t          = 0;
            exp_seg    = 7'h7F;
            exp_seg_nb = 7'h7F;
            exp_an     = 8'hFF;
            exp_uflow  = '0;
            exp_pos    = -1;
            for (int c = 0; c < NUM_CH; c++) mval[c] = 0;
        end else begin
            t++;
            exp_pos    = ((t - 1) / DIV) % TOTAL;
            ch         = exp_pos / DIGITS;
            k          = exp_pos % DIGITS;
            d          = (mval[ch] / pow10(k)) % 10;
            exp_seg_nb = seg_of(d);
            exp_seg    = (k > 0 && mval[ch] < pow10(k)) ? 7'h7F : seg_of(d);
            exp_an     = ~(8'd1 << exp_pos);
            for (int c = 0; c < NUM_CH; c++) begin
                exp_uflow[c] = 1'b0;
                if (clr[c]) mval[c] = 0;
                else if (inc[c] && dec[c]) mval[c] = mval[c];
                else if (inc[c]) begin
                    if (mval[c] < 9999) mval[c] = mval[c] + 1;
                end else if (dec[c]) begin
                    if (mval[c] == 0) exp_uflow[c] = 1'b1;
                    else mval[c] = mval[c] - 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inc = '0; dec = '0; clr = '0;
        repeat (3) tick();
        checks++;
        if (bus0.Count_Out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_count got=%h want=%h", bus0.Count_Out, 32'h0);
        end
        checks++;
        if (bus0.An_Out !== 8'hFF || bus0.Seg_Out !== 7'h7F) begin
            failures++;
            $display("[TB] FAIL reset_pins got an=%h seg=%h want an=ff seg=7f", bus0.An_Out, bus0.Seg_Out);
        end
        checks++;
        if (bus0.Sat_Out !== 2'b00 || bus0.Uflow_Out !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_flags got sat=%b uflow=%b want 00/00", bus0.Sat_Out, bus0.Uflow_Out);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus0.An_Out !== 8'hFE) begin
            failures++;
            $display("[TB] FAIL first_anode got=%h want=fe", bus0.An_Out);
        end
        for (int i = 0; i < 2 * DIV * TOTAL; i++) begin
            tick();
            checks++;
            if (bus0.An_Out !== exp_an) begin
                failures++;
                $display("[TB] FAIL anode_walk t=%0d got=%h want=%h", t, bus0.An_Out, exp_an);
            end
        end
    endtask

    task automatic test_inc_1234();
        inc = 2'b01;
        repeat (1234) tick();
        inc = '0;
        tick();
        checks++;
        if (bus0.Count_Out[15:0] !== 16'h1234 || bus0.Count_Out !== exp_count()) begin
            failures++;
            $display("[TB] FAIL inc_1234 got=%h want=%h", bus0.Count_Out, exp_count());
        end
        checks++;
        if (bus0.Count_Out[31:16] !== 16'h0 || bus0.Sat_Out !== 2'b00) begin
            failures++;
            $display("[TB] FAIL inc_1234_ch1 got ch1=%h sat=%b want 0000/00", bus0.Count_Out[31:16], bus0.Sat_Out);
        end
    endtask

    task automatic test_saturate();
        inc = 2'b10;
        repeat (9999) tick();
        checks++;
        if (bus0.Count_Out[31:16] !== 16'h9999 || bus0.Sat_Out[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_reach got=%h sat=%b want 9999/1", bus0.Count_Out[31:16], bus0.Sat_Out[1]);
        end
        tick();
        inc = '0;
        checks++;
        if (bus0.Count_Out[31:16] !== 16'h9999 || bus0.Sat_Out !== exp_sat()) begin
            failures++;
            $display("[TB] FAIL sat_hold got=%h sat=%b want 9999/%b", bus0.Count_Out[31:16], bus0.Sat_Out, exp_sat());
        end
        dec = 2'b10;
        tick();
        dec = '0;
        checks++;
        if (bus0.Count_Out[31:16] !== 16'h9998 || bus0.Sat_Out[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_dec got=%h sat=%b want 9998/0", bus0.Count_Out[31:16], bus0.Sat_Out[1]);
        end
    endtask

    task automatic test_underflow();
        clr = 2'b01;
        tick();
        clr = '0;
        dec = 2'b01;
        tick();
        dec = '0;
        checks++;
        if (bus0.Uflow_Out !== 2'b01 || bus0.Count_Out[15:0] !== 16'h0) begin
            failures++;
            $display("[TB] FAIL uflow_pulse got uflow=%b cnt=%h want 01/0000", bus0.Uflow_Out, bus0.Count_Out[15:0]);
        end
        tick();
        checks++;
        if (bus0.Uflow_Out !== 2'b00) begin
            failures++;
            $display("[TB] FAIL uflow_width got=%b want=00", bus0.Uflow_Out);
        end
        inc = 2'b01;
        repeat (42) tick();
        inc = 2'b01; dec = 2'b01;
        tick();
        inc = '0; dec = '0;
        checks++;
        if (bus0.Count_Out[15:0] !== 16'h0042 || bus0.Uflow_Out !== 2'b00 || bus0.Sat_Out !== 2'b00) begin
            failures++;
            $display("[TB] FAIL inc_dec_cancel got=%h uflow=%b sat=%b want 0042/00/00",
                     bus0.Count_Out[15:0], bus0.Uflow_Out, bus0.Sat_Out);
        end
        clr = 2'b01; inc = 2'b01;
        tick();
        clr = '0; inc = '0;
        checks++;
        if (bus0.Count_Out !== exp_count() || bus0.Count_Out[15:0] !== 16'h0) begin
            failures++;
            $display("[TB] FAIL clear_priority got=%h want=%h", bus0.Count_Out, exp_count());
        end
    endtask

    task automatic test_blanking();
        clr = 2'b01;
        tick();
        clr = '0;
        inc = 2'b01;
        repeat (7) tick();
        inc = '0;
        for (int i = 0; i < 2 * DIV * TOTAL; i++) begin
            tick();
            checks++;
            if (bus0.Seg_Out !== exp_seg || bus1.Seg_Out !== exp_seg_nb) begin
                failures++;
                $display("[TB] FAIL blank_model pos=%0d got=%h/%h want=%h/%h",
                         exp_pos, bus0.Seg_Out, bus1.Seg_Out, exp_seg, exp_seg_nb);
            end
            if (exp_pos >= 1 && exp_pos <= 3) begin
                checks++;
                if (bus0.Seg_Out !== 7'h7F || bus1.Seg_Out !== 7'h40) begin
                    failures++;
                    $display("[TB] FAIL blank_lead pos=%0d got=%h/%h want=7f/40", exp_pos, bus0.Seg_Out, bus1.Seg_Out);
                end
            end else if (exp_pos == 0) begin
                checks++;
                if (bus0.Seg_Out !== 7'h78) begin
                    failures++;
                    $display("[TB] FAIL blank_digit0 got=%h want=78", bus0.Seg_Out);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        clr = 2'b01;
        tick();
        clr = '0;
        inc = 2'b01;
        repeat (100) tick();
        inc = '0;
        found = 1'b0;
        for (int i = 0; i < 4 * DIV * TOTAL && !found; i++) begin
            tick();
            if (exp_an == 8'hDF) found = 1'b1;
        end
        checks++;
        if (!found || bus0.An_Out !== 8'hDF) begin
            failures++;
            $display("[TB] FAIL mid_reset_reach got=%h want=df", bus0.An_Out);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus0.Count_Out !== 32'h0 || bus0.An_Out !== 8'hFF || bus0.Seg_Out !== 7'h7F || bus0.Sat_Out !== 2'b00) begin
            failures++;
            $display("[TB] FAIL mid_reset got cnt=%h an=%h seg=%h sat=%b want 0/ff/7f/00",
                     bus0.Count_Out, bus0.An_Out, bus0.Seg_Out, bus0.Sat_Out);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus0.An_Out !== 8'hFE || bus0.Seg_Out !== exp_seg) begin
            failures++;
            $display("[TB] FAIL mid_reset_restart got an=%h seg=%h want fe/%h", bus0.An_Out, bus0.Seg_Out, exp_seg);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            inc = 2'($urandom_range(0, 3));
            dec = 2'($urandom_range(0, 3));
            clr[0] = ($urandom_range(0, 15) == 0);
            clr[1] = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (bus0.Count_Out !== exp_count() || bus0.Sat_Out !== exp_sat() || bus0.Uflow_Out !== exp_uflow) begin
                failures++;
                $display("[TB] FAIL random_count i=%0d got=%h/%b/%b want=%h/%b/%b", i,
                         bus0.Count_Out, bus0.Sat_Out, bus0.Uflow_Out, exp_count(), exp_sat(), exp_uflow);
            end
            checks++;
            if (bus0.Seg_Out !== exp_seg || bus1.Seg_Out !== exp_seg_nb || bus0.An_Out !== exp_an) begin
                failures++;
                $display("[TB] FAIL random_scan i=%0d got=%h/%h/%h want=%h/%h/%h", i,
                         bus0.Seg_Out, bus1.Seg_Out, bus0.An_Out, exp_seg, exp_seg_nb, exp_an);
            end
        end
        inc = '0; dec = '0; clr = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        t        = 0;
        exp_pos  = -1;
        rst_n    = 1'b0;
        inc      = '0;
        dec      = '0;
        clr      = '0;
        for (int c = 0; c < NUM_CH; c++) mval[c] = 0;
        #1;
        test_reset();
        test_inc_1234();
        test_saturate();
        test_underflow();
        test_blanking();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
